// File: rtl/stack_dump_pkg.sv
// Shared definitions for the stack read-out engine: FSM encoding and the
// layout of the depth header word.
package stack_dump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_WALK = 2'd2,
    ST_DONE = 2'd3
  } dump_state_e;

  // Header word carries the depth in its low bits; everything above is zero.
  localparam int HDR_DEPTH_LSB = 0;

endpackage

// File: rtl/stack_dump_if.sv
// Stack-memory read port plus the outbound valid/ready word stream of the
// stack read-out engine.
interface stack_dump_if #(
  parameter int saddr_width = 8,
  parameter int width       = 16
);
  logic [saddr_width-1:0] rd_addr;
  logic [width-1:0]       rd_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [width-1:0]       out_data;
  logic                   out_last;

  modport master (
    output rd_addr,
    input  rd_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last
  );
endinterface

// File: rtl/stack_dump.sv
// Debug read-out of the data/return stack: freezes the core, streams a depth
// header and then entries from top-of-stack down to slot 1.
module stack_dump
  import stack_dump_pkg::*;
#(
  parameter int saddr_width = 8,
  parameter int width       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dump_req,
  input  logic [saddr_width-1:0] sp,
  output logic                   hold,
  output logic                   busy,
  stack_dump_if.master           bus
);

  dump_state_e            state_q, state_d;
  logic [saddr_width-1:0] depth_q, depth_d;
  logic [saddr_width-1:0] cursor_q, cursor_d;

  logic [saddr_width-1:0] rd_addr_c;
  logic                   out_valid_c;
  logic [width-1:0]       out_data_c;
  logic                   out_last_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      depth_q  <= '0;
      cursor_q <= '0;
    end else begin
      state_q  <= state_d;
      depth_q  <= depth_d;
      cursor_q <= cursor_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    cursor_d    = cursor_q;
    rd_addr_c   = '0;
    out_valid_c = 1'b0;
    out_data_c  = '0;
    out_last_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dump_req) begin
          depth_d  = sp;
          cursor_d = sp;
          state_d  = ST_HDR;
        end
      end

      ST_HDR: begin
        out_valid_c = 1'b1;
        out_data_c[HDR_DEPTH_LSB +: saddr_width] = depth_q;
        out_last_c  = (depth_q == '0);
        if (bus.out_ready) begin
          state_d = (depth_q == '0) ? ST_DONE : ST_WALK;
        end
      end

      // Memory is frozen by hold, so the async read data is stable under stall.
      ST_WALK: begin
        rd_addr_c   = cursor_q;
        out_valid_c = 1'b1;
        out_data_c  = bus.rd_data;
        out_last_c  = (cursor_q == saddr_width'(1));
        if (bus.out_ready) begin
          if (cursor_q == saddr_width'(1)) begin
            state_d = ST_DONE;
          end else begin
            cursor_d = cursor_q - saddr_width'(1);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Freeze the core in the accept cycle too, so the sp snapshot is exact.
  assign hold = (state_q != ST_IDLE) | dump_req;
  assign busy = (state_q != ST_IDLE);

  assign bus.rd_addr   = rd_addr_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_c;
  assign bus.out_last  = out_last_c;

endmodule

// File: tb/tb_stack_dump.sv
// Randomized bench for stack_dump: each dump is checked against an expected
// word list built directly from the stack contents.
module tb_stack_dump;

  localparam int SAW = 3;
  localparam int W   = 16;
  localparam int DEPTH_MAX = (1 << SAW) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           dump_req;
  logic [SAW-1:0] sp_r;
  logic           hold;
  logic           busy;
  logic [W-1:0]   mem [0:DEPTH_MAX];

  int n_checks = 0;
  int n_errors = 0;

  stack_dump_if #(.saddr_width(SAW), .width(W)) bus ();

  stack_dump #(.saddr_width(SAW), .width(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .dump_req (dump_req),
    .sp       (sp_r),
    .hold     (hold),
    .busy     (busy),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  assign bus.rd_data = mem[bus.rd_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ready patterns: 0 = always ready, 1 = 0,0,1 per word, 2 = random.
  // Called at posedge+1 with the DUT idle; returns at posedge+1, idle again.
  task automatic do_dump(input string name, input int ready_pat, input bit poke_busy);
    logic [W-1:0] exp_q[$];
    int idx;
    int stall;
    int cycles;
    int n;
    int handshakes;

    exp_q.delete();
    exp_q.push_back(W'(sp_r));
    for (int a = int'(sp_r); a >= 1; a--) exp_q.push_back(mem[a]);
    n = exp_q.size();

    dump_req = 1'b1;
    #1;
    check("hold_req", hold, 1'b1);
    check("busy_req", busy, 1'b0);
    @(posedge clk);
    #1;
    dump_req = 1'b0;

    idx = 0; stall = 0; cycles = 0; handshakes = 0;
    while (idx < n && cycles < 200) begin
      case (ready_pat)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (stall == 2);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      dump_req = poke_busy && (idx == 1) && (stall == 0);
      #1;
      check("valid", bus.out_valid, 1'b1);
      check("hold_busy", hold, 1'b1);
      check("data", bus.out_data, exp_q[idx]);
      check("last", bus.out_last, (idx == n - 1));
      if (idx >= 1) check("rd_addr", bus.rd_addr, 32'(int'(sp_r) - (idx - 1)));
      if (bus.out_ready) begin
        idx++;
        handshakes++;
        stall = 0;
      end else begin
        stall++;
      end
      @(posedge clk);
      #1;
      dump_req = 1'b0;
      cycles++;
    end
    check("words", handshakes, n);

    // One release-gap cycle with hold still asserted, then back to idle.
    bus.out_ready = 1'b0;
    check("done_valid", bus.out_valid, 1'b0);
    check("done_hold", hold, 1'b1);
    @(posedge clk);
    #1;
    check("idle_hold", hold, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_valid", bus.out_valid, 1'b0);
    $display("dump %s sp=%0d words=%0d cycles=%0d", name, sp_r, handshakes, cycles);
  endtask

  task automatic load_three();
    for (int a = 0; a <= DEPTH_MAX; a++) mem[a] = 16'hDEAD;
    mem[1] = 16'h1111;
    mem[2] = 16'h2222;
    mem[3] = 16'h3333;
    sp_r   = 3'd3;
  endtask

  initial begin
    logic [W-1:0] mem_snap [0:DEPTH_MAX];

    reset = 1'b1;
    dump_req = 1'b0;
    bus.out_ready = 1'b0;
    sp_r = '0;
    for (int a = 0; a <= DEPTH_MAX; a++) mem[a] = '0;

    repeat (2) @(posedge clk);
    #1;
    dump_req = 1'b1;
    #1;
    check("rst_hold_req", hold, 1'b1);
    dump_req = 1'b0;
    #1;
    check("rst_hold", hold, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_last", bus.out_last, 1'b0);
    check("rst_data", bus.out_data, 16'h0);
    check("rst_addr", bus.rd_addr, 3'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Ready asserted while idle must not start anything.
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("idle_ready_busy", busy, 1'b0);
    check("idle_ready_valid", bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;

    sp_r = 3'd0;
    do_dump("empty", 0, 1'b0);

    load_three();
    do_dump("three", 0, 1'b0);

    load_three();
    for (int a = 0; a <= DEPTH_MAX; a++) mem_snap[a] = mem[a];
    do_dump("backpressure", 1, 1'b0);
    for (int a = 0; a <= DEPTH_MAX; a++) check("mem_kept", mem[a], mem_snap[a]);

    load_three();
    do_dump("req_while_busy", 0, 1'b1);
    sp_r = 3'd2;
    do_dump("after_busy_req", 0, 1'b0);

    // Reset in the middle of a walk abandons the stream without a last word.
    for (int a = 1; a <= DEPTH_MAX; a++) mem[a] = W'(16'h5000 + a);
    sp_r = 3'd5;
    dump_req = 1'b1;
    @(posedge clk);
    #1;
    dump_req = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("mid_hdr", bus.out_data, 16'h0005);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_valid", bus.out_valid, 1'b0);
    check("mid_busy", busy, 1'b0);
    check("mid_hold", hold, 1'b0);
    check("mid_last", bus.out_last, 1'b0);
    @(posedge clk);
    #1;
    sp_r = 3'd2;
    do_dump("post_reset", 0, 1'b0);

    for (int a = 1; a <= DEPTH_MAX; a++) mem[a] = W'(16'hA000 + a * 16'h0101);
    sp_r = 3'd7;
    do_dump("wrap", 0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      for (int a = 0; a <= DEPTH_MAX; a++) mem[a] = W'($urandom);
      sp_r = SAW'($urandom_range(0, DEPTH_MAX));
      do_dump("random", 2, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stack_dump.md
Name: stack_dump

Overview:
- Debug read-out engine for the data/return stack, i.e. the reader side of the stack memory that the core's push/pop logic writes.
- On request it freezes the core through its wait-state input, snapshots the stack pointer, and walks stack memory from top-of-stack down to entry 1.
- It streams a depth header word, then each entry, over a valid/ready byte-agnostic word stream to the debug/UART transmit path.
- It implements the `.S`-style inspection needed by the monitor without disturbing stack contents or SP.

Parameters:
- saddr_width, 8, stack address width; stack holds entries 1..2**saddr_width-1, slot 0 is the empty-stack sentinel.
- width, 16, stack word width; must be >= saddr_width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- dump_req  in  1  single-cycle or level request; sampled only in IDLE.
- sp  in  saddr_width  current stack pointer of the target stack (top-of-stack index).
- rd_addr  out  saddr_width  read address into stack memory; asynchronous read.
- rd_data  in  width  stack memory word at rd_addr, valid in the same cycle.
- hold  out  1  drives the core's wait_state; while high, SP and memory must not change.
- busy  out  1  high in any state other than IDLE.
- out_valid  out  1  stream word valid.
- out_ready  in  1  stream sink ready.
- out_data  out  width  stream word.
- out_last  out  1  marks the final word of a dump.

Behaviour:
- Reset: state IDLE; out_valid=0, out_last=0, out_data=0, busy=0, rd_addr=0, cursor=0, depth=0. hold=0 unless dump_req is high in the reset cycle (hold is combinational, see below).
- hold = (state!=IDLE) | (state==IDLE & dump_req). The core is therefore frozen in the accept cycle itself, so the sp snapshot is exact.
- FSM states: IDLE, HDR, WALK, DONE.
- IDLE: on dump_req:
  - depth <= sp, cursor <= sp.
  - Next state HDR.
- HDR:
  - out_valid=1, out_data=zero-extended depth, out_last=(depth==0).
  - On out_valid&out_ready: go to DONE if depth==0, else WALK.
- WALK:
  - rd_addr=cursor; out_valid=1; out_data=rd_data (combinational pass-through, stable while stalled because memory is frozen); out_last=(cursor==1).
  - On handshake: if cursor==1 go to DONE, else cursor <= cursor-1.
- DONE: one cycle with out_valid=0 and hold still high, then IDLE. This gives a guaranteed release gap; a new dump_req is accepted earliest the cycle after DONE.
- Handshake rules:
  - out_valid never drops without a handshake.
  - out_data and out_last are stable while out_valid & !out_ready.
  - Back-to-back handshakes transfer one word per cycle.
- Ordering: top-of-stack first (address sp), down to address 1. Slot 0 is never emitted.
- Total words per dump = depth+1.
- Wrap-around: sp is treated as an unsigned count; an underflowed stack (sp=2**saddr_width-1 after pop from 0) dumps all 2**saddr_width-1 entries. The cursor never decrements below 1.
- dump_req while busy: ignored (no queuing).
- Reset mid-dump: immediate return to IDLE; hold drops the cycle after reset deasserts (if dump_req low); a partial stream is abandoned with no out_last.
- out_ready high while out_valid low: no effect.

Decomposition:
- Shared package: FSM state encoding (IDLE/HDR/WALK/DONE), the header-word format constant (depth in low saddr_width bits, upper bits zero), and the stream word/last bundle type if a typedef is used.
- No sub-module is needed; the FSM, cursor down-counter and output mux live in one module.
- Optional stream skid buffer: the existing shared one is reused only if a later timing review requires it; it is not part of this block.

Test Plan:
- Empty stack: sp=0, pulse dump_req, out_ready=1 → hold high in request cycle; one word 0x0000 with out_last=1; hold low 2 cycles after handshake (DONE gap).
- Three entries: mem[1..3]=0x1111,0x2222,0x3333, sp=3, ready=1 → stream 0x0003, 0x3333, 0x2222, 0x1111(last); rd_addr sequence 3,2,1; exactly 4 handshakes.
- Back-pressure: same setup with out_ready toggling 0,0,1 per word → each word held stable 3 cycles; no word dropped or duplicated; sp and mem unchanged after dump.
- Request while busy: second dump_req pulse during WALK → ignored; only one header observed; new dump accepted after return to IDLE.
- Reset mid-dump: assert reset after header handshake with sp=5 → next cycle out_valid=0, busy=0, out_last never seen; subsequent dump with sp=2 streams 0x0002 plus 2 entries correctly.
- Wrap: saddr_width=3, sp=7 (underflow) → header 0x0007, then 7 entries from addresses 7..1, last on address 1.
